// File: rtl/msb_scan_scheduler_if.sv
// Handshake bundle for msb_scan_scheduler.
//   master : request producer / index consumer side (drives in_valid, in_mask,
//            abort, out_ready)
//   slave  : the scheduler (drives in_ready, out_* and the done/status flags)
interface msb_scan_scheduler_if #(
  parameter int N = 8
);
  localparam int IW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_mask;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_index;
  logic          out_last;
  logic          done;
  logic          empty;
  logic          aborted;
  logic          busy;

  modport master (
    output in_valid, in_mask, abort, out_ready,
    input  in_ready, out_valid, out_index, out_last, done, empty, aborted, busy
  );

  modport slave (
    input  in_valid, in_mask, abort, out_ready,
    output in_ready, out_valid, out_index, out_last, done, empty, aborted, busy
  );
endinterface

// File: rtl/msb_scan_scheduler.sv
// msb_scan_scheduler: accepts an N-bit request mask and issues the indices of
// its set bits one per handshake, highest first, clearing each issued bit.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : slave side of msb_scan_scheduler_if
//          in_valid/in_ready/in_mask  : mask acceptance (only in IDLE)
//          abort                      : synchronous abort of a running scan
//          out_valid/out_ready        : index handshake
//          out_index/out_last         : highest pending bit / final bit flag
//          done/empty/aborted         : one-cycle completion pulse + qualifiers
//          busy                       : scan in progress
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no pending bits; ready to accept a mask
// SCAN  | pending != 0; presenting highest pending bit on out_index
module msb_scan_scheduler #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  msb_scan_scheduler_if.slave  bus
);
  localparam int IW = $clog2(N);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]    state;
  logic [N-1:0]  pending;
  logic          done_q;
  logic          empty_q;
  logic          aborted_q;

  logic [IW-1:0] hi_idx;
  logic          single_bit;
  logic [N-1:0]  hi_onehot;

  // Ascending scan so the last hit (the highest set bit) wins.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) hi_idx = IW'(i);
    end
  end

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign single_bit = (pending != '0) && ((pending & (pending - N'(1))) == '0);
  assign hi_onehot  = N'(1) << hi_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      pending   <= '0;
      done_q    <= 1'b0;
      empty_q   <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      empty_q   <= 1'b0;
      aborted_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_mask != '0) begin
              pending <= bus.in_mask;
              state   <= S_SCAN;
            end else begin
              done_q  <= 1'b1;
              empty_q <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          // abort wins over a same-cycle handshake
          if (bus.abort) begin
            pending   <= '0;
            state     <= S_IDLE;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
          end else if (bus.out_ready) begin
            pending <= pending & ~hi_onehot;
            if (single_bit) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: begin
          state   <= S_IDLE;
          pending <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state == S_SCAN);
  assign bus.out_valid = (state == S_SCAN);
  assign bus.out_index = hi_idx;
  assign bus.out_last  = single_bit;
  assign bus.done      = done_q;
  assign bus.empty     = empty_q;
  assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_msb_scan_scheduler.sv
module tb_msb_scan_scheduler;
  logic clk;
  logic rst;
  logic rst32;

  int n_vec = 0;
  int n_err = 0;

  msb_scan_scheduler_if #(.N(8))  b8 ();
  msb_scan_scheduler_if #(.N(32)) b32 ();

  msb_scan_scheduler #(.N(8))  dut8  (.clk(clk), .rst(rst),   .bus(b8));
  msb_scan_scheduler #(.N(32)) dut32 (.clk(clk), .rst(rst32), .bus(b32));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle8(input string tag);
    chk({tag, "_out_valid"}, int'(b8.out_valid), 0);
    chk({tag, "_busy"},      int'(b8.busy),      0);
    chk({tag, "_in_ready"},  int'(b8.in_ready),  1);
    chk({tag, "_out_index"}, int'(b8.out_index), 0);
    chk({tag, "_out_last"},  int'(b8.out_last),  0);
  endtask

  typedef struct {
    logic [7:0] mask;
    int         first;
    int         count;
    bit         is_empty;
  } vec_t;

  vec_t vecs[7];

  // Apply one mask with out_ready held high; checks first index, number of
  // SCAN cycles, a single out_last at the end and the done qualifiers.
  task automatic run_vec(input vec_t v);
    int cycles;
    int nlast;
    int last_at;
    b8.in_valid  = 1'b1;
    b8.in_mask   = v.mask;
    b8.out_ready = 1'b1;
    b8.abort     = 1'b0;
    @(negedge clk);
    b8.in_valid = 1'b0;
    chk("vec_first_valid", int'(b8.out_valid), (v.count > 0) ? 1 : 0);
    if (v.count > 0) chk("vec_first_idx", int'(b8.out_index), v.first);
    cycles  = 0;
    nlast   = 0;
    last_at = -1;
    while (b8.busy && cycles < 40) begin
      if (b8.out_last) begin
        nlast++;
        last_at = cycles;
      end
      cycles++;
      @(negedge clk);
    end
    chk("vec_scan_cycles", cycles, v.count);
    chk("vec_nlast", nlast, (v.count > 0) ? 1 : 0);
    if (v.count > 0) chk("vec_last_pos", last_at, v.count - 1);
    chk("vec_done",    int'(b8.done),    1);
    chk("vec_empty",   int'(b8.empty),   v.is_empty ? 1 : 0);
    chk("vec_aborted", int'(b8.aborted), 0);
    chk("vec_in_ready_at_done", int'(b8.in_ready), 1);
    @(negedge clk);
    chk("vec_done_drop", int'(b8.done), 0);
  endtask

  // Reference model for the random phase: the pending set as a queue of
  // indices in issue order, plus expected status flags for the next cycle.
  int m_q[$];
  bit m_done, m_empty, m_aborted;

  task automatic rand_step();
    int exp_idx;
    logic [7:0] mask;
    exp_idx = (m_q.size() > 0) ? m_q[0] : 0;
    chk("rnd_out_valid", int'(b8.out_valid), (m_q.size() > 0) ? 1 : 0);
    chk("rnd_busy",      int'(b8.busy),      (m_q.size() > 0) ? 1 : 0);
    chk("rnd_in_ready",  int'(b8.in_ready),  (m_q.size() > 0) ? 0 : 1);
    chk("rnd_out_index", int'(b8.out_index), exp_idx);
    chk("rnd_out_last",  int'(b8.out_last),  (m_q.size() == 1) ? 1 : 0);
    chk("rnd_done",      int'(b8.done),      int'(m_done));
    chk("rnd_empty",     int'(b8.empty),     int'(m_empty));
    chk("rnd_aborted",   int'(b8.aborted),   int'(m_aborted));

    mask = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
    b8.in_valid  = ($urandom_range(0, 1) == 1);
    b8.in_mask   = mask;
    b8.abort     = ($urandom_range(0, 15) == 0);
    b8.out_ready = ($urandom_range(0, 3) != 0);

    m_done = 0; m_empty = 0; m_aborted = 0;
    if (m_q.size() == 0) begin
      if (b8.in_valid) begin
        if (mask == 8'h00) begin
          m_done = 1; m_empty = 1;
        end else begin
          for (int i = 7; i >= 0; i--) if (mask[i]) m_q.push_back(i);
        end
      end
    end else if (b8.abort) begin
      m_q.delete();
      m_done = 1; m_aborted = 1;
    end else if (b8.out_ready) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_done = 1;
    end
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{mask: 8'b00100100, first: 5, count: 2, is_empty: 0};
    vecs[1] = '{mask: 8'hFF,       first: 7, count: 8, is_empty: 0};
    vecs[2] = '{mask: 8'h00,       first: 0, count: 0, is_empty: 1};
    vecs[3] = '{mask: 8'h01,       first: 0, count: 1, is_empty: 0};
    vecs[4] = '{mask: 8'h80,       first: 7, count: 1, is_empty: 0};
    vecs[5] = '{mask: 8'b01010000, first: 6, count: 2, is_empty: 0};
    vecs[6] = '{mask: 8'h3C,       first: 5, count: 4, is_empty: 0};

    rst = 1'b1;
    rst32 = 1'b1;
    b8.in_valid = 0;  b8.in_mask = '0;  b8.abort = 0;  b8.out_ready = 0;
    b32.in_valid = 0; b32.in_mask = '0; b32.abort = 0; b32.out_ready = 0;
    #2;
    chk_idle8("rst");
    chk("rst_done",    int'(b8.done),    0);
    chk("rst_empty",   int'(b8.empty),   0);
    chk("rst_aborted", int'(b8.aborted), 0);
    chk("rst32_out_valid", int'(b32.out_valid), 0);
    chk("rst32_in_ready",  int'(b32.in_ready),  1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rst32 = 1'b0;
    @(negedge clk);
    chk_idle8("post_rst");

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Stall: index 7 held for four cycles while out_ready is low.
    b8.in_valid = 1; b8.in_mask = 8'b10000001; b8.out_ready = 0;
    @(negedge clk);
    b8.in_valid = 0;
    for (int c = 0; c < 4; c++) begin
      chk("stall_idx",   int'(b8.out_index), 7);
      chk("stall_last",  int'(b8.out_last),  0);
      chk("stall_valid", int'(b8.out_valid), 1);
      if (c == 3) b8.out_ready = 1;
      @(negedge clk);
    end
    chk("stall_idx2",  int'(b8.out_index), 0);
    chk("stall_last2", int'(b8.out_last),  1);
    @(negedge clk);
    chk("stall_done", int'(b8.done), 1);
    chk("stall_busy", int'(b8.busy), 0);
    @(negedge clk);

    // Abort together with the second handshake, then immediate new mask.
    b8.in_valid = 1; b8.in_mask = 8'b11110000; b8.out_ready = 1;
    @(negedge clk);
    b8.in_valid = 0;
    chk("abort_idx0", int'(b8.out_index), 7);
    @(negedge clk);
    chk("abort_idx1", int'(b8.out_index), 6);
    b8.abort = 1;
    @(negedge clk);
    b8.abort = 0;
    chk("abort_done",    int'(b8.done),    1);
    chk("abort_aborted", int'(b8.aborted), 1);
    chk("abort_empty",   int'(b8.empty),   0);
    chk_idle8("abort");
    b8.in_valid = 1; b8.in_mask = 8'b00000010;
    @(negedge clk);
    b8.in_valid = 0;
    chk("reacc_valid", int'(b8.out_valid), 1);
    chk("reacc_idx",   int'(b8.out_index), 1);
    chk("reacc_last",  int'(b8.out_last),  1);
    chk("reacc_done",  int'(b8.done),      0);
    @(negedge clk);
    chk("reacc_done2", int'(b8.done), 1);
    @(negedge clk);
    @(negedge clk);
    chk_idle8("pre_rand");

    // N=32: asynchronous reset mid-scan.
    b32.in_valid = 1; b32.in_mask = 32'h8000_0001; b32.out_ready = 1;
    @(negedge clk);
    b32.in_valid = 0;
    chk("n32_idx0", int'(b32.out_index), 31);
    @(negedge clk);
    chk("n32_idx1", int'(b32.out_index), 0);
    #1 rst32 = 1'b1;
    #1;
    chk("n32_rst_valid", int'(b32.out_valid), 0);
    chk("n32_rst_busy",  int'(b32.busy),      0);
    chk("n32_rst_ready", int'(b32.in_ready),  1);
    chk("n32_rst_idx",   int'(b32.out_index), 0);
    chk("n32_rst_last",  int'(b32.out_last),  0);
    #1 rst32 = 1'b0;
    @(negedge clk);
    chk("n32_no_done", int'(b32.done), 0);
    b32.in_valid = 1; b32.in_mask = 32'h0001_0000;
    @(negedge clk);
    b32.in_valid = 0;
    chk("n32_idx16",  int'(b32.out_index), 16);
    chk("n32_last16", int'(b32.out_last),  1);
    @(negedge clk);
    chk("n32_done", int'(b32.done), 1);

    // Random phase against the queue model.
    m_q.delete();
    m_done = 0; m_empty = 0; m_aborted = 0;
    for (int s = 0; s < 800; s++) rand_step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
